// File: rtl/d_mdu_ctrl.sv
// Multiply/divide unit control: decodes D-stage MDU ops, registers them into E,
// stalls D while the MDU is occupied and cross-checks its busy flag.
module d_mdu_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] D_instr,
  input  logic        E_busy,
  output logic [3:0]  E_sel_MDU,
  output logic        stall_D,
  output logic        busy_shadow,
  output logic        mismatch,
  output logic [31:0] stall_cnt,
  output logic [31:0] op_cnt
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  localparam logic [3:0] MULT_LAT_C = 4'(MULT_LAT);
  localparam logic [3:0] DIV_LAT_C  = 4'(DIV_LAT);

  mdu_op_e     d_sel;
  mdu_op_e     e_sel_reg, e_sel_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        mismatch_reg, mismatch_next;
  logic [31:0] stall_cnt_reg, stall_cnt_next;
  logic [31:0] op_cnt_reg, op_cnt_next;
  logic        e_start;
  logic        e_is_div;

  // SPECIAL-opcode decode; everything else is a non-MDU instruction.
  always_comb begin
    d_sel = OP_NONE;
    if (D_instr[31:26] == 6'b000000) begin
      case (D_instr[5:0])
        6'h18:   d_sel = OP_MULT;
        6'h19:   d_sel = OP_MULTU;
        6'h1A:   d_sel = OP_DIV;
        6'h1B:   d_sel = OP_DIVU;
        6'h10:   d_sel = OP_MFHI;
        6'h12:   d_sel = OP_MFLO;
        6'h11:   d_sel = OP_MTHI;
        6'h13:   d_sel = OP_MTLO;
        default: d_sel = OP_NONE;
      endcase
    end
  end

  assign e_start     = (e_sel_reg == OP_MULT) || (e_sel_reg == OP_MULTU) ||
                       (e_sel_reg == OP_DIV)  || (e_sel_reg == OP_DIVU);
  assign e_is_div    = (e_sel_reg == OP_DIV)  || (e_sel_reg == OP_DIVU);
  assign busy_shadow = (cnt_reg != 4'd0);
  assign stall_D     = (d_sel != OP_NONE) && (e_start || busy_shadow);

  always_comb begin
    e_sel_next     = d_sel;
    cnt_next       = cnt_reg;
    mismatch_next  = mismatch_reg | (busy_shadow != E_busy);
    stall_cnt_next = stall_cnt_reg;
    op_cnt_next    = op_cnt_reg;

    if (req || stall_D) begin
      e_sel_next = OP_NONE;
    end

    // Under req the MDU accepts nothing and freezes, so the shadow does too.
    if (!req) begin
      if (cnt_reg != 4'd0) begin
        cnt_next = cnt_reg - 4'd1;
      end else if (e_start) begin
        cnt_next = e_is_div ? DIV_LAT_C : MULT_LAT_C;
      end
      if (stall_D && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_next = stall_cnt_reg + 32'd1;
      end
      if (e_start) begin
        op_cnt_next = op_cnt_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_sel_reg     <= OP_NONE;
      cnt_reg       <= 4'd0;
      mismatch_reg  <= 1'b0;
      stall_cnt_reg <= 32'd0;
      op_cnt_reg    <= 32'd0;
    end else begin
      e_sel_reg     <= e_sel_next;
      cnt_reg       <= cnt_next;
      mismatch_reg  <= mismatch_next;
      stall_cnt_reg <= stall_cnt_next;
      op_cnt_reg    <= op_cnt_next;
    end
  end

  assign E_sel_MDU = e_sel_reg;
  assign mismatch  = mismatch_reg;
  assign stall_cnt = stall_cnt_reg;
  assign op_cnt    = op_cnt_reg;

endmodule

// File: tb/tb_d_mdu_ctrl.sv
// Directed bench for d_mdu_ctrl with a small MDU busy model driving E_busy.
module tb_d_mdu_ctrl;

  localparam logic [31:0] I_NOP   = 32'h0000_0000;
  localparam logic [31:0] I_MULT  = 32'h0000_0018;
  localparam logic [31:0] I_DIVU  = 32'h0000_001B;
  localparam logic [31:0] I_DIV   = 32'h0000_001A;
  localparam logic [31:0] I_MFHI  = 32'h0000_0010;
  localparam logic [31:0] I_MFLO  = 32'h0000_4012;
  localparam logic [31:0] I_MTHI  = 32'h0000_0011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [31:0] D_instr = 32'd0;
  logic        E_busy;
  logic [3:0]  E_sel_MDU;
  logic        stall_D;
  logic        busy_shadow;
  logic        mismatch;
  logic [31:0] stall_cnt;
  logic [31:0] op_cnt;

  int errors = 0;
  int checks = 0;

  logic [3:0] mdu_cnt;
  logic       force_busy = 1'b0;

  d_mdu_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .D_instr    (D_instr),
    .E_busy     (E_busy),
    .E_sel_MDU  (E_sel_MDU),
    .stall_D    (stall_D),
    .busy_shadow(busy_shadow),
    .mismatch   (mismatch),
    .stall_cnt  (stall_cnt),
    .op_cnt     (op_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural MDU: busy for 4 (mult) or 9 (div) cycles after a start edge, frozen by req.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdu_cnt <= 4'd0;
    end else if (!req) begin
      if (mdu_cnt != 4'd0)                      mdu_cnt <= mdu_cnt - 4'd1;
      else if (E_sel_MDU == 4'd1 || E_sel_MDU == 4'd2) mdu_cnt <= 4'd4;
      else if (E_sel_MDU == 4'd3 || E_sel_MDU == 4'd4) mdu_cnt <= 4'd9;
    end
  end
  assign E_busy = force_busy | (mdu_cnt != 4'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    D_instr = I_NOP;
    req     = 1'b0;
    reset   = 1'b0;
    #2;
    reset   = 1'b1;
  endtask

  // Issue first op, then hold second op in D for a fixed window counting stall/busy cycles.
  task automatic run_pair(input logic [31:0] first, input logic [31:0] second,
                          input int window, output int n_stall, output int n_busy);
    n_stall = 0;
    n_busy  = 0;
    D_instr = first;
    tick();
    D_instr = second;
    for (int i = 0; i < window; i++) begin
      #1;
      if (stall_D)     n_stall++;
      if (busy_shadow) n_busy++;
      tick();
    end
  endtask

  logic [31:0] dec_vec [9] = '{32'h0000_0018, 32'h0000_0019, 32'h0000_001A, 32'h0000_001B,
                               32'h0000_0010, 32'h0000_0012, 32'h0000_0011, 32'h0000_0013,
                               32'h8C00_0018};
  logic [3:0]  dec_exp [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ns, nb, guard;

    // Reset values and reset in the middle of a divide
    #3;
    check("rst_esel", {28'd0, E_sel_MDU}, 32'd0);
    check("rst_busy", {31'd0, busy_shadow}, 32'd0);
    check("rst_mism", {31'd0, mismatch}, 32'd0);
    check("rst_stallcnt", stall_cnt, 32'd0);
    check("rst_opcnt", op_cnt, 32'd0);
    reset   = 1'b1;
    D_instr = I_DIV;
    tick();
    check("div_esel", {28'd0, E_sel_MDU}, 32'd3);
    D_instr = I_NOP;
    tick();
    check("div_busy", {31'd0, busy_shadow}, 32'd1);
    check("div_opcnt", op_cnt, 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_esel", {28'd0, E_sel_MDU}, 32'd0);
    check("midrst_busy", {31'd0, busy_shadow}, 32'd0);
    check("midrst_opcnt", op_cnt, 32'd0);
    check("midrst_stallcnt", stall_cnt, 32'd0);
    check("midrst_stallD", {31'd0, stall_D}, 32'd0);
    reset = 1'b1;
    tick();

    // Mult then mflo: 5 stalled cycles, mflo enters E on the edge after
    do_reset();
    D_instr = I_MULT;
    tick();
    check("mult_esel", {28'd0, E_sel_MDU}, 32'd1);
    D_instr = I_MFLO;
    ns = 0;
    guard = 0;
    #1;
    while (stall_D === 1'b1 && guard < 20) begin
      ns++;
      guard++;
      tick();
    end
    check("mult_stalls", ns, 32'd5);
    tick();
    check("mflo_esel", {28'd0, E_sel_MDU}, 32'd6);
    check("mult_stallcnt", stall_cnt, 32'd5);
    check("mult_opcnt", op_cnt, 32'd1);
    check("mult_mism", {31'd0, mismatch}, 32'd0);

    // Divu then mfhi
    do_reset();
    run_pair(I_DIVU, I_MFHI, 14, ns, nb);
    check("divu_stalls", ns, 32'd10);
    check("divu_busy", nb, 32'd9);
    check("divu_esel", {28'd0, E_sel_MDU}, 32'd5);
    check("divu_stallcnt", stall_cnt, 32'd10);
    check("divu_mism", {31'd0, mismatch}, 32'd0);

    // req for two cycles mid-mult stretches busy to 6 and suppresses stall counting
    do_reset();
    D_instr = I_MULT;
    tick();
    D_instr = I_MFLO;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      req = (i == 2 || i == 3);
      #1;
      if (busy_shadow) nb++;
      tick();
    end
    req = 1'b0;
    check("req_busy", nb, 32'd6);
    check("req_stallcnt", stall_cnt, 32'd5);
    check("req_esel", {28'd0, E_sel_MDU}, 32'd6);
    check("req_mism", {31'd0, mismatch}, 32'd0);
    D_instr = I_MTHI;
    tick();
    check("mthi_esel", {28'd0, E_sel_MDU}, 32'd7);
    req = 1'b1;
    tick();
    check("req_squash", {28'd0, E_sel_MDU}, 32'd0);
    req = 1'b0;

    // Decode sweep
    for (int i = 0; i < 9; i++) begin
      do_reset();
      D_instr = dec_vec[i];
      tick();
      check($sformatf("dec_%08h", dec_vec[i]), {28'd0, E_sel_MDU}, {28'd0, dec_exp[i]});
    end

    // Sticky mismatch
    do_reset();
    tick();
    check("mism_clear", {31'd0, mismatch}, 32'd0);
    force_busy = 1'b1;
    tick();
    check("mism_set", {31'd0, mismatch}, 32'd1);
    force_busy = 1'b0;
    tick();
    tick();
    check("mism_sticky", {31'd0, mismatch}, 32'd1);
    do_reset();
    #1;
    check("mism_reset", {31'd0, mismatch}, 32'd0);

    // Stall counter saturation
    do_reset();
    tick();
    dut.stall_cnt_reg = 32'hFFFF_FFFE;
    run_pair(I_MULT, I_MFLO, 3, ns, nb);
    check("sat_stallcnt", stall_cnt, 32'hFFFF_FFFF);
    tick();
    tick();
    tick();
    check("sat_hold", stall_cnt, 32'hFFFF_FFFF);

    // Op counter wrap
    do_reset();
    tick();
    dut.op_cnt_reg = 32'hFFFF_FFFF;
    D_instr = I_MULT;
    tick();
    D_instr = I_NOP;
    tick();
    check("wrap_opcnt", op_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/d_mdu_ctrl.md
# d_mdu_ctrl

Decode and hazard controller for the multiply/divide unit in the pipeline.
- Decodes the D-stage instruction into a 4-bit MDU operation code.
- Registers that code into the E stage, where it drives the MDU's operation select.
- Stalls the D stage while the MDU is occupied, tracking occupancy with its own shadow countdown.
- Cross-checks the MDU's busy flag against that countdown.
- Keeps two performance counters.

## Interface
Parameters:
- MULT_LAT, default 4: cycles busy is high after a mult/multu issue edge.
- DIV_LAT, default 9: cycles busy is high after a div/divu issue edge.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  interrupt/exception flush. When 1, the E-stage op is squashed and the countdown freezes, matching the MDU's own freeze.
- D_instr  in  32  D-stage instruction word.
- E_busy  in  1  busy flag from the MDU.
- E_sel_MDU  out  4  registered E-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
- stall_D  out  1  hold the F/D stages; a bubble enters E.
- busy_shadow  out  1  1 while the countdown is non-zero.
- mismatch  out  1  sticky error flag; set when busy_shadow differs from E_busy.
- stall_cnt  out  32  saturating count of stalled cycles.
- op_cnt  out  32  wrapping count of issued mult/multu/div/divu ops.

## Operation
- Decode (combinational, D_sel):
  - Applies only when opcode D_instr[31:26] = 6'b000000; any other instruction gives D_sel = 0.
  - funct D_instr[5:0] mapping:
    - 0x18 → 1, 0x19 → 2, 0x1A → 3, 0x1B → 4
    - 0x10 → 5, 0x12 → 6, 0x11 → 7, 0x13 → 8
    - any other funct → 0
- E_start = E_sel_MDU in {1..4}.
- stall_D = (D_sel ≠ 0) & (E_start | busy_shadow). All MDU-class ops stall, including mthi/mtlo/mfhi/mflo.
- Pipeline register, priority order:
  1. req = 1 → E_sel_MDU ← 0.
  2. stall_D = 1 → E_sel_MDU ← 0 (bubble).
  3. Otherwise → E_sel_MDU ← D_sel.
- Countdown cnt (4 bits) states, all only when req = 0:
  - IDLE (cnt = 0): if E_start, load cnt ← MULT_LAT for ops 1/2, or DIV_LAT for ops 3/4.
  - RUN (cnt > 0): cnt ← cnt − 1 each cycle; reaches 0 on the same edge the MDU clears busy.
  - req = 1: cnt holds its value in either state. E_start is ignored on that edge, matching the MDU, which accepts nothing under req.
- busy_shadow = (cnt ≠ 0).
- mismatch:
  - Set on any edge where busy_shadow ≠ E_busy.
  - Cleared only by reset.
- stall_cnt: +1 on each edge with stall_D = 1 and req = 0; saturates at 0xFFFFFFFF.
- op_cnt: +1 on each edge with E_start = 1 and req = 0; wraps modulo 2^32.

## Timing
- Reset (asynchronous, reset = 0): E_sel_MDU = 0, cnt = 0, busy_shadow = 0, mismatch = 0, stall_cnt = 0, op_cnt = 0. stall_D then follows its combinational definition with cnt = 0.
- Decode to E: 1 cycle. An op seen in D at edge N appears on E_sel_MDU after edge N.
- Mult issued at edge N (E_sel_MDU = 1 during cycle N+1):
  - Edge N+1: cnt ← 4.
  - busy_shadow high during cycles N+2..N+5; cnt = 0 after edge N+5.
  - Div: busy_shadow high for 9 cycles.
- A dependent MDU op waiting in D is stalled from cycle N+1 through the last busy cycle, and enters E on the edge after cnt reaches 0.
- Back-to-back non-starting ops (mfhi, mtlo, etc.) do not stall each other. They stall only behind a start or busy.
- A req pulse during RUN extends busy by exactly the number of req cycles.
- stall_D depends on the current registers and D_instr only; no internal combinational loop.

## Test plan
- Reset mid-run: release reset, issue div (D_instr = 0x0000001A), assert reset = 0 two cycles later → E_sel_MDU = 0, busy_shadow = 0, counters = 0, stall_D = 0 for a non-MDU D_instr.
- Mult then mflo: mult (0x00000018), then mflo (0x00004012) → stall_D high for 5 cycles (1 start + 4 busy); mflo reaches E_sel_MDU = 6 on the following edge; stall_cnt = 5, op_cnt = 1.
- Divu then mfhi: divu then mfhi → stall_D high for 10 cycles; busy_shadow high for exactly 9; mismatch stays 0 when E_busy is driven from a correct MDU model.
- req during busy: req = 1 for 2 cycles in the middle of a mult → busy_shadow high for 6 cycles total; stall_cnt does not increment while req = 1; an op in E during req becomes 0.
- Decode sweep and mismatch: all 8 funct codes plus a non-SPECIAL opcode (0x8C000018) → codes 1..8 and 0 respectively. Then force E_busy = 1 while cnt = 0 → mismatch = 1 and remains set until reset.
- Saturation and wrap: preload stall_cnt to 0xFFFFFFFE and stall for 3 cycles → stall_cnt = 0xFFFFFFFF. Preload op_cnt to 0xFFFFFFFF and issue one mult → op_cnt = 0.
